// File: rtl/tap_delay_pkg.sv
// Shared constants and parameter helpers for the tap delay bank and its channels.
package tap_delay_pkg;

    localparam int DEFAULT_NCHAN     = 24;
    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_DEPTH     = 32;
    localparam int DEFAULT_DELAY_VAL = 0;
    localparam int CHAN_W            = 8;

    // Tap-select width; a depth of 1 would otherwise yield a zero-width select.
    function automatic int sel_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Legal depths are powers of two from 2 to 256.
    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && (depth <= 256) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/tap_delay_chan.sv
// One delay channel: shift register, post-shift tap mux, saturating fill counter
// and output-valid flag.
module tap_delay_chan
    import tap_delay_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int SELW  = sel_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ce_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic [SELW-1:0]  delay_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o
);

    localparam int FILLW = SELW + 1;

    // The oldest stage is only ever read through the post-shift view, where it
    // equals stage DEPTH-2 of the stored history, so it needs no register.
    logic [DEPTH-2:0][WIDTH-1:0] sr_q;
    logic [DEPTH-1:0][WIDTH-1:0] sr_d;
    logic [FILLW-1:0]            fill_q;
    logic [FILLW-1:0]            fill_d;
    logic [WIDTH-1:0]            dout_q;
    logic                        valid_q;

    always_comb begin
        sr_d   = {sr_q, din_i};
        fill_d = (fill_q == FILLW'(DEPTH)) ? fill_q : fill_q + FILLW'(1);
    end

    // NOTE: the shift history is reset and flushed like any other state, so it
    // stays in flops rather than RAM; stale words must never reach dout_o.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr_q    <= '0;
            fill_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            sr_q    <= '0;
            fill_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else if (ce_i) begin
            sr_q    <= sr_d[DEPTH-2:0];
            fill_q  <= fill_d;
            dout_q  <= sr_d[delay_i];
            valid_q <= (fill_d > {1'b0, delay_i});
        end
    end

    assign dout_o  = dout_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/tap_delay_bank.sv
// Multi-channel programmable delay line: config decode, per-channel delay
// registers, write acknowledge, and NCHAN delay channels.
module tap_delay_bank
    import tap_delay_pkg::*;
#(
    parameter int NCHAN         = DEFAULT_NCHAN,
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int SELW          = sel_width(DEPTH),
    parameter int DEFAULT_DELAY = DEFAULT_DELAY_VAL
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   ce,
    input  logic                   flush,
    input  logic [NCHAN*WIDTH-1:0] din,
    input  logic                   cfg_wr,
    input  logic [CHAN_W-1:0]      cfg_chan,
    input  logic [SELW-1:0]        cfg_delay,
    output logic                   cfg_ack,
    output logic                   cfg_err,
    output logic [SELW-1:0]        cfg_rdata,
    output logic [NCHAN*WIDTH-1:0] dout,
    output logic [NCHAN-1:0]       dout_valid
);

    logic [NCHAN-1:0][SELW-1:0] delay_q;
    logic [NCHAN-1:0][SELW-1:0] delay_d;
    logic                       cfg_ack_q;
    logic                       cfg_err_q;
    logic [SELW-1:0]            cfg_rdata_q;
    logic [SELW-1:0]            cfg_rdata_d;
    logic                       chan_ok;

    assign chan_ok = (int'(cfg_chan) < NCHAN);

    // NOTE: every output of this block gets its default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        delay_d     = delay_q;
        cfg_rdata_d = cfg_rdata_q;
        if (cfg_wr && chan_ok) begin
            cfg_rdata_d = cfg_delay;
            for (int c = 0; c < NCHAN; c++) begin
                if (int'(cfg_chan) == c) begin
                    delay_d[c] = cfg_delay;
                end
            end
        end
    end

    // NOTE: combinational blocks use blocking '=', clocked state uses '<=' so all
    // registers update together from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            delay_q     <= {NCHAN{SELW'(DEFAULT_DELAY)}};
            cfg_ack_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_rdata_q <= '0;
        end else begin
            delay_q     <= delay_d;
            cfg_ack_q   <= cfg_wr;
            cfg_err_q   <= cfg_wr && !chan_ok;
            cfg_rdata_q <= cfg_rdata_d;
        end
    end

    assign cfg_ack   = cfg_ack_q;
    assign cfg_err   = cfg_err_q;
    assign cfg_rdata = cfg_rdata_q;

    // Delay writes land in delay_q on the write edge, so channels see the new
    // tap from the next enabled edge onward.
    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        tap_delay_chan #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .SELW  (SELW)
        ) u_chan (
            .clock   (clock),
            .reset_n (reset_n),
            .ce_i    (ce),
            .flush_i (flush),
            .din_i   (din[c*WIDTH +: WIDTH]),
            .delay_i (delay_q[c]),
            .dout_o  (dout[c*WIDTH +: WIDTH]),
            .valid_o (dout_valid[c])
        );
    end

endmodule

// File: tb/tb_tap_delay_bank.sv
// Scoreboard bench for tap_delay_bank: stimulus pushes expected outputs, a
// negedge monitor pops and compares them against the DUT.
module tb_tap_delay_bank;

    localparam int NCHAN = 24;
    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int SELW  = 5;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic                   ce;
    logic                   flush;
    logic [NCHAN*WIDTH-1:0] din;
    logic                   cfg_wr;
    logic [7:0]             cfg_chan;
    logic [SELW-1:0]        cfg_delay;
    logic                   cfg_ack;
    logic                   cfg_err;
    logic [SELW-1:0]        cfg_rdata;
    logic [NCHAN*WIDTH-1:0] dout;
    logic [NCHAN-1:0]       dout_valid;

    always #5 clock = ~clock;

    tap_delay_bank #(
        .NCHAN         (NCHAN),
        .WIDTH         (WIDTH),
        .DEPTH         (DEPTH),
        .SELW          (SELW),
        .DEFAULT_DELAY (0)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ce         (ce),
        .flush      (flush),
        .din        (din),
        .cfg_wr     (cfg_wr),
        .cfg_chan   (cfg_chan),
        .cfg_delay  (cfg_delay),
        .cfg_ack    (cfg_ack),
        .cfg_err    (cfg_err),
        .cfg_rdata  (cfg_rdata),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    typedef struct {
        int               chan;
        logic             valid;
        logic [WIDTH-1:0] data;
    } dexp_t;

    typedef struct {
        logic            err;
        logic [SELW-1:0] rdata;
    } cexp_t;

    dexp_t dq[$];
    cexp_t cq[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: outputs registered on the preceding posedge are compared here.
    always @(negedge clock) begin : monitor
        dexp_t e;
        cexp_t c;
        while (dq.size() != 0) begin
            e = dq.pop_front();
            check($sformatf("ch%0d valid", e.chan), 32'(dout_valid[e.chan]), 32'(e.valid));
            check($sformatf("ch%0d dout", e.chan), 32'(dout[e.chan*WIDTH +: WIDTH]), 32'(e.data));
        end
        if (cq.size() != 0) begin
            c = cq.pop_front();
            check("cfg_ack", 32'(cfg_ack), 1);
            check("cfg_err", 32'(cfg_err), 32'(c.err));
            check("cfg_rdata", 32'(cfg_rdata), 32'(c.rdata));
        end else if (cfg_ack) begin
            check("unexpected cfg_ack", 32'(cfg_ack), 0);
        end
    end

    task automatic step(input logic ce_v, input logic flush_v, input int word);
        ce    = ce_v;
        flush = flush_v;
        din   = {NCHAN{word[WIDTH-1:0]}};
        @(posedge clock);
        @(negedge clock);
        #1;
        cfg_wr = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic cfg_write(input int chan, input int dly, input logic err, input int rdata);
        cexp_t c;
        cfg_wr    = 1'b1;
        cfg_chan  = 8'(chan);
        cfg_delay = SELW'(dly);
        c.err     = err;
        c.rdata   = SELW'(rdata);
        cq.push_back(c);
    endtask

    task automatic expect_raw(input int chan, input logic v, input int data);
        dexp_t e;
        e.chan  = chan;
        e.valid = v;
        e.data  = WIDTH'(data);
        dq.push_back(e);
    endtask

    // Stream word n at enabled edge n (counted from the last flush/reset):
    // the tap at delay d shows word n-d once n > d, zeros before that.
    task automatic expect_stream(input int chan, input int dly, input int n);
        expect_raw(chan, n > dly, (n > dly) ? n - dly : 0);
    endtask

    task automatic run(input int chan, input int dly, input int first, input int last);
        for (int n = first; n <= last; n++) begin
            expect_stream(chan, dly, n);
            step(1'b1, 1'b0, n);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        ce        = 1'b0;
        flush     = 1'b0;
        cfg_wr    = 1'b0;
        cfg_chan  = '0;
        cfg_delay = '0;
        din       = '0;
        repeat (2) @(negedge clock);
        #1 reset_n = 1'b1;

        check("reset dout nonzero", 32'(dout != '0), 0);
        check("reset dout_valid", 32'(dout_valid), 0);
        check("reset cfg_ack", 32'(cfg_ack), 0);
        check("reset cfg_err", 32'(cfg_err), 0);
        check("reset cfg_rdata", 32'(cfg_rdata), 0);

        // Delay 0 on channel 0: word n appears at edge n, valid from edge 1.
        run(0, 0, 1, 4);

        // Flush together with a write of ch3 delay 5; then write ch1 delay 4.
        cfg_write(3, 5, 1'b0, 5);
        expect_raw(3, 1'b0, 0);
        step(1'b1, 1'b1, 8'h55);
        cfg_write(1, 4, 1'b0, 4);
        run(3, 5, 1, 8);

        // Saturate fill on ch1, then raise its delay 4 -> 31.
        run(1, 4, 9, 40);
        cfg_write(1, 31, 1'b0, 31);
        expect_raw(1, 1'b1, 37);
        step(1'b1, 1'b0, 41);
        run(1, 31, 42, 44);

        // Flush with ce low; valid returns after 32 enabled edges.
        expect_raw(1, 1'b0, 0);
        expect_raw(3, 1'b0, 0);
        step(1'b0, 1'b1, 8'h77);
        run(1, 31, 1, 33);

        // Out-of-range channel: error ack, nothing written, rdata kept.
        cfg_write(30, 7, 1'b1, 31);
        expect_raw(1, 1'b1, 2);
        step(1'b0, 1'b0, 8'hAA);
        expect_stream(1, 31, 34);
        expect_stream(0, 0, 34);
        expect_stream(3, 5, 34);
        step(1'b1, 1'b0, 34);

        // ce gaps on ch5 with delay 2: outputs hold, latency counts enabled edges.
        cfg_write(5, 2, 1'b0, 2);
        expect_raw(5, 1'b0, 0);
        step(1'b0, 1'b1, 0);
        run(5, 2, 1, 4);
        repeat (2) begin
            expect_raw(5, 1'b1, 2);
            step(1'b0, 1'b0, 8'hEE);
        end
        run(5, 2, 5, 6);

        // Async reset with a write pending: outputs clear at once, write lost.
        cfg_wr    = 1'b1;
        cfg_chan  = 8'd2;
        cfg_delay = SELW'(9);
        #2 reset_n = 1'b0;
        #1;
        check("async reset dout nonzero", 32'(dout != '0), 0);
        check("async reset dout_valid", 32'(dout_valid), 0);
        check("async reset cfg_ack", 32'(cfg_ack), 0);
        check("async reset cfg_rdata", 32'(cfg_rdata), 0);
        @(posedge clock);
        @(negedge clock);
        cfg_wr = 1'b0;
        #1 reset_n = 1'b1;
        expect_stream(1, 0, 1);
        expect_stream(5, 0, 1);
        expect_stream(2, 0, 1);
        step(1'b1, 1'b0, 1);
        check("no cfg_ack after reset", 32'(cfg_ack), 0);

        // cfg_wr held across two edges: two writes, two acks.
        cfg_write(7, 3, 1'b0, 3);
        step(1'b0, 1'b0, 0);
        cfg_write(8, 4, 1'b0, 4);
        step(1'b0, 1'b1, 0);
        for (int n = 1; n <= 5; n++) begin
            expect_stream(7, 3, n);
            expect_stream(8, 4, n);
            step(1'b1, 1'b0, n);
        end

        @(negedge clock);
        check("scoreboard drained", dq.size() + cq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tap_delay_bank.md
Name: tap_delay_bank

Overview:
- Multi-channel programmable delay line for trigger-path S-bit and start-of-frame alignment.
- Each channel is a DEPTH-deep shift register with a runtime-selectable output tap, set per channel through a write/ack config port.
- Per-channel fill tracking flags outputs as valid only once the selected tap holds real history.
- Sits between the input deserialisers and the trigger aligner; also used in benches to inject known skews.

Parameters:
- NCHAN, 24, number of independent channels.
- WIDTH, 8, bits per channel per clock (one deserialised word).
- DEPTH, 32, shift-register depth; power of two, 2..256.
- SELW, $clog2(DEPTH), tap-select width.
- DEFAULT_DELAY, 0, delay loaded into every channel at reset; must be < DEPTH.

Ports:
- clock  in  1  single clock domain for all logic.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; shifting, output update and fill counting occur only when high.
- flush  in  1  synchronous clear of all shift data and fill counters.
- din  in  NCHAN*WIDTH  input words; channel c occupies [c*WIDTH+:WIDTH].
- cfg_wr  in  1  config write strobe; single-cycle pulse.
- cfg_chan  in  8  target channel for the write.
- cfg_delay  in  SELW  new tap value for the target channel.
- cfg_ack  out  1  one-cycle acknowledge, asserted the cycle after cfg_wr.
- cfg_err  out  1  qualifies cfg_ack: high when cfg_chan >= NCHAN.
- cfg_rdata  out  SELW  current delay of the channel last addressed.
- dout  out  NCHAN*WIDTH  delayed words, registered.
- dout_valid  out  NCHAN  per-channel validity of dout.

Behaviour:
- Reset (async assert, sync deassert upstream):
  - Shift data, dout, dout_valid, cfg_ack, cfg_err, cfg_rdata all 0.
  - Every delay register set to DEFAULT_DELAY; fill counters 0.
- Shift: on each clock edge with ce=1, sr[c] <= {sr[c][DEPTH-2:0], din[c]}; stage 0 holds the newest word.
- Output: on each edge with ce=1, dout[c] <= sr_next[c][delay[c]] (post-shift value). Delay d means din sampled at ce-cycle t appears on dout after ce-cycle t+d+1, i.e. d+1 ce-cycles of latency.
- ce=0: sr, dout, dout_valid and fill hold. The config port still operates.
- Fill counter:
  - Per channel, saturating at DEPTH; increments by one per ce cycle.
  - dout_valid[c] <= (fill_next[c] > delay[c]) on ce edges.
- Delay change:
  - A new delay takes effect on the first ce edge after the write edge; there is no flush.
  - Increasing the delay beyond the current fill drops dout_valid until fill catches up.
  - Decreasing the delay keeps valid high.
  - dout may jump (words repeated or skipped); this is the required behaviour.
- Config handshake:
  - cfg_wr sampled at edge N writes delay[cfg_chan] and cfg_rdata <= cfg_delay.
  - cfg_ack=1 for exactly cycle N+1.
  - If cfg_chan >= NCHAN: no write, cfg_err=1 with the ack, cfg_rdata unchanged.
  - cfg_wr held high for multiple cycles is treated as back-to-back writes, one ack per cycle.
- flush:
  - Clears sr, fill, dout and dout_valid on that edge, regardless of ce.
  - Delays are kept.
  - flush with simultaneous cfg_wr: both take effect.
- Wrap: fill saturates at DEPTH and never wraps; delay DEPTH-1 is legal.

Decomposition:
- Shared package tap_delay_pkg: SELW derivation function, DEPTH legality check, default constants.
- One sub-module tap_delay_chan: shift register, tap mux, fill counter and valid for a single channel, instantiated NCHAN times in a generate loop.
- Top level holds the config decode, the delay register file and the ack/err logic.

Test Plan:
- Reset, then din[0]=0x01,0x02,... with ce=1 and delay 0 -> dout[0]=0x01 one ce-cycle after the first word; dout_valid[0]=1 from that same edge.
- Write ch3 delay=5, then stream to ch3 -> cfg_ack 1 cycle after the write with cfg_err=0; dout[3] lags din[3] by 6 ce-cycles; valid rises on the 6th ce edge.
- Steady state with fill=32, change ch1 delay 4->31 -> valid stays 1 and dout jumps to the 32-cycle-old word; after flush, valid returns only after 32 ce-cycles.
- Write to cfg_chan=30 (NCHAN=24) -> cfg_ack=1 and cfg_err=1; all delays unchanged; cfg_rdata unchanged.
- Toggle ce 1,0,0,1 with delay=2 -> dout and valid hold during ce=0; latency counts ce-cycles only (3 enabled edges).
- Assert reset_n low mid-stream with a cfg_wr pending -> all outputs 0 immediately (async); delays return to DEFAULT_DELAY; no cfg_ack follows reset.
